// File: rtl/pc_pkg.sv
// Shared definitions for the PC fetch sequencer: FSM states and PC constants.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_RUN      = 2'd1,
        ST_WAIT_MEM = 2'd2,
        ST_REDIRECT = 2'd3
    } pc_state_e;

    localparam int unsigned PC_INCR          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection: redirect target, sequential PC+4 or hold.
module pc_next_mux
    import pc_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 32
) (
    input  pc_state_e             i_state,
    input  logic                  i_stall,
    input  logic                  i_imem_ready,
    input  logic                  i_branch_taken,
    input  logic [PC_WIDTH-1:0]   i_branch_target,
    input  logic                  i_jump,
    input  logic [PC_WIDTH-1:0]   i_jump_target,
    input  logic [PC_WIDTH-1:0]   i_pc,
    output logic [PC_WIDTH-1:0]   o_pc_plus4,
    output logic [PC_WIDTH-1:0]   o_next_pc,
    output logic                  o_take_redirect,
    output logic                  o_misaligned
);

    logic                w_redirect_ok;
    logic [PC_WIDTH-1:0] w_target;

    assign o_pc_plus4 = i_pc + PC_WIDTH'(PC_INCR);

    // Redirects are only meaningful once the pipeline holds instructions, and jump beats branch.
    always_comb begin
        w_redirect_ok   = (i_state != ST_HOLD);
        w_target        = i_jump ? i_jump_target : i_branch_target;
        o_take_redirect = w_redirect_ok & (i_jump | i_branch_taken);
        o_misaligned    = o_take_redirect & (|w_target[1:0]);
        o_next_pc       = i_pc;
        if (o_take_redirect) begin
            o_next_pc = {w_target[PC_WIDTH-1:2], 2'b00};
        end else if (i_state == ST_RUN && i_imem_ready && !i_stall) begin
            o_next_pc = o_pc_plus4;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer for the MIPS datapath.
module pc_fetch_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned          PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned          HOLD_CYCLES = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Stall,
    input  logic                 BranchTaken,
    input  logic [PC_WIDTH-1:0]  BranchTarget,
    input  logic                 Jump,
    input  logic [PC_WIDTH-1:0]  JumpTarget,
    input  logic                 ImemReady,
    output logic [PC_WIDTH-1:0]  PCResult,
    output logic [PC_WIDTH-1:0]  PCAddResult,
    output logic                 FetchValid,
    output logic                 FlushIF,
    output logic                 AlignFault
);

    pc_state_e           r_state;
    pc_state_e           w_state_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [3:0]          r_hold_cnt;
    logic                r_flush;
    logic                r_align_fault;

    logic [PC_WIDTH-1:0] w_next_pc;
    logic [PC_WIDTH-1:0] w_pc_plus4;
    logic                w_take_redirect;
    logic                w_misaligned;

    pc_next_mux #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_mux (
        .i_state         (r_state),
        .i_stall         (Stall),
        .i_imem_ready    (ImemReady),
        .i_branch_taken  (BranchTaken),
        .i_branch_target (BranchTarget),
        .i_jump          (Jump),
        .i_jump_target   (JumpTarget),
        .i_pc            (r_pc),
        .o_pc_plus4      (w_pc_plus4),
        .o_next_pc       (w_next_pc),
        .o_take_redirect (w_take_redirect),
        .o_misaligned    (w_misaligned)
    );

    assign PCResult    = r_pc;
    assign PCAddResult = w_pc_plus4;
    assign FlushIF     = r_flush;
    assign AlignFault  = r_align_fault;
    assign FetchValid  = (r_state == ST_RUN) & ImemReady & ~Stall;

    // State, PC, hold counter and registered flags; reset wins over everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= ST_HOLD;
            r_pc          <= RESET_PC;
            r_hold_cnt    <= '0;
            r_flush       <= 1'b0;
            r_align_fault <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_next_pc;
            r_flush       <= w_take_redirect;
            r_align_fault <= w_misaligned;
            if (r_state == ST_HOLD) begin
                r_hold_cnt <= r_hold_cnt + 4'd1;
            end
        end
    end

    // Next-state decode; redirect takes priority in every post-HOLD state.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_HOLD: begin
                if (r_hold_cnt == 4'(HOLD_CYCLES - 1)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_take_redirect) begin
                    w_state_next = ST_REDIRECT;
                end else if (Stall) begin
                    w_state_next = ST_RUN;
                end else if (!ImemReady) begin
                    w_state_next = ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: begin
                if (w_take_redirect) begin
                    w_state_next = ST_REDIRECT;
                end else if (ImemReady) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                w_state_next = w_take_redirect ? ST_REDIRECT : ST_RUN;
            end
            default: w_state_next = ST_HOLD;
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with hand-computed expectations.
module tb_pc_fetch_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        ImemReady;
    logic [31:0] PCResult;
    logic [31:0] PCAddResult;
    logic        FetchValid;
    logic        FlushIF;
    logic        AlignFault;

    int unsigned n_chk;
    int unsigned n_err;

    pc_fetch_sequencer #(
        .PC_WIDTH    (32),
        .RESET_PC    (32'h0000_0000),
        .HOLD_CYCLES (2)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .ImemReady    (ImemReady),
        .PCResult     (PCResult),
        .PCAddResult  (PCAddResult),
        .FetchValid   (FetchValid),
        .FlushIF      (FlushIF),
        .AlignFault   (AlignFault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Edge then 1 time unit: inputs for the new cycle are driven after this.
    task automatic edge_in();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_chk        = 0;
        n_err        = 0;
        Reset        = 1'b1;
        Stall        = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = '0;
        Jump         = 1'b0;
        JumpTarget   = '0;
        ImemReady    = 1'b1;

        edge_in();
        #1;
        chk("rst_pc", PCResult, 32'h0);
        chk("rst_flush", {31'b0, FlushIF}, 32'h0);
        chk("rst_af", {31'b0, AlignFault}, 32'h0);
        chk("rst_fv", {31'b0, FetchValid}, 32'h0);
        Reset = 1'b0;
        #1;
        chk("hold0_pc", PCResult, 32'h0);
        chk("hold0_fv", {31'b0, FetchValid}, 32'h0);

        // Branch during HOLD must be ignored
        edge_in();
        BranchTaken  = 1'b1;
        BranchTarget = 32'h500;
        #1;
        chk("hold1_pc", PCResult, 32'h0);
        chk("hold1_fv", {31'b0, FetchValid}, 32'h0);

        edge_in();
        BranchTaken = 1'b0;
        #1;
        chk("run0_pc", PCResult, 32'h0);
        chk("run0_fv", {31'b0, FetchValid}, 32'h1);
        chk("run0_flush", {31'b0, FlushIF}, 32'h0);
        chk("run0_add", PCAddResult, 32'h4);

        for (int i = 1; i <= 4; i++) begin
            edge_in();
            #1;
            chk("seq_pc", PCResult, 32'(i * 4));
            chk("seq_fv", {31'b0, FetchValid}, 32'h1);
        end

        // Stall three cycles at 0x10
        Stall = 1'b1;
        #1;
        chk("stall0_fv", {31'b0, FetchValid}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            edge_in();
            #1;
            chk("stall_pc", PCResult, 32'h10);
            chk("stall_fv", {31'b0, FetchValid}, 32'h0);
        end
        edge_in();
        Stall = 1'b0;
        #1;
        chk("unstall_pc", PCResult, 32'h10);
        chk("unstall_fv", {31'b0, FetchValid}, 32'h1);

        for (int i = 0; i < 4; i++) begin
            edge_in();
            #1;
            chk("seq2_pc", PCResult, 32'h14 + 32'(i * 4));
        end

        // Branch at 0x20 to 0x100
        BranchTaken  = 1'b1;
        BranchTarget = 32'h100;
        #1;
        edge_in();
        BranchTaken = 1'b0;
        #1;
        chk("br_pc", PCResult, 32'h100);
        chk("br_flush", {31'b0, FlushIF}, 32'h1);
        chk("br_fv", {31'b0, FetchValid}, 32'h0);
        chk("br_af", {31'b0, AlignFault}, 32'h0);
        edge_in();
        #1;
        chk("br1_flush", {31'b0, FlushIF}, 32'h0);
        chk("br1_fv", {31'b0, FetchValid}, 32'h1);
        chk("br1_pc", PCResult, 32'h100);

        // Jump and branch together: jump wins
        edge_in();
        Jump         = 1'b1;
        JumpTarget   = 32'h400;
        BranchTaken  = 1'b1;
        BranchTarget = 32'h100;
        #1;
        chk("jb_pre_pc", PCResult, 32'h104);
        edge_in();
        Jump        = 1'b0;
        BranchTaken = 1'b0;
        #1;
        chk("jb_pc", PCResult, 32'h400);
        chk("jb_flush", {31'b0, FlushIF}, 32'h1);

        // Memory not ready for two cycles
        edge_in();
        ImemReady = 1'b0;
        #1;
        chk("nr0_pc", PCResult, 32'h400);
        chk("nr0_fv", {31'b0, FetchValid}, 32'h0);
        chk("nr0_flush", {31'b0, FlushIF}, 32'h0);
        edge_in();
        #1;
        chk("wait0_pc", PCResult, 32'h400);
        chk("wait0_fv", {31'b0, FetchValid}, 32'h0);

        // Misaligned branch while waiting
        edge_in();
        BranchTaken  = 1'b1;
        BranchTarget = 32'h202;
        #1;
        chk("wait1_pc", PCResult, 32'h400);
        edge_in();
        BranchTaken = 1'b0;
        ImemReady   = 1'b1;
        Jump        = 1'b1;
        JumpTarget  = 32'h240;
        #1;
        chk("mis_pc", PCResult, 32'h200);
        chk("mis_flush", {31'b0, FlushIF}, 32'h1);
        chk("mis_af", {31'b0, AlignFault}, 32'h1);
        chk("mis_fv", {31'b0, FetchValid}, 32'h0);

        // Back-to-back redirect accepted in REDIRECT
        edge_in();
        Jump = 1'b0;
        #1;
        chk("rr_pc", PCResult, 32'h240);
        chk("rr_flush", {31'b0, FlushIF}, 32'h1);
        chk("rr_af", {31'b0, AlignFault}, 32'h0);

        edge_in();
        Jump       = 1'b1;
        JumpTarget = 32'hFFFF_FFFC;
        #1;
        chk("rr1_pc", PCResult, 32'h240);
        chk("rr1_flush", {31'b0, FlushIF}, 32'h0);
        chk("rr1_fv", {31'b0, FetchValid}, 32'h1);

        // Wraparound of PC+4
        edge_in();
        Jump = 1'b0;
        #1;
        chk("wrap_pc", PCResult, 32'hFFFF_FFFC);
        chk("wrap_add", PCAddResult, 32'h0);
        edge_in();
        #1;
        chk("wrap1_pc", PCResult, 32'hFFFF_FFFC);
        chk("wrap1_fv", {31'b0, FetchValid}, 32'h1);
        edge_in();
        #1;
        chk("wrap2_pc", PCResult, 32'h0);
        chk("wrap2_add", PCAddResult, 32'h4);

        // Reset during REDIRECT
        Jump       = 1'b1;
        JumpTarget = 32'h300;
        #1;
        edge_in();
        Jump  = 1'b0;
        Reset = 1'b1;
        #1;
        chk("rr_rst_pre_pc", PCResult, 32'h300);
        chk("rr_rst_pre_flush", {31'b0, FlushIF}, 32'h1);
        edge_in();
        Reset = 1'b0;
        #1;
        chk("rst2_pc", PCResult, 32'h0);
        chk("rst2_flush", {31'b0, FlushIF}, 32'h0);
        chk("rst2_fv", {31'b0, FetchValid}, 32'h0);
        chk("rst2_af", {31'b0, AlignFault}, 32'h0);
        edge_in();
        #1;
        chk("rst2_hold1_fv", {31'b0, FetchValid}, 32'h0);
        edge_in();
        #1;
        chk("rst2_run_fv", {31'b0, FetchValid}, 32'h1);
        chk("rst2_run_pc", PCResult, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
